pc_gen: RTL and testbench
=========================

# pc_gen

Parametrised fetch-address generator for the pipelined CPU, sitting at the head of the IF stage and driving the instruction-memory address and the PC passed down the pipeline. It extends a plain PC register with configurable reset and exception vectors, ERET return, and a one-entry pending-redirect buffer so that a branch or jump resolved during a stall is never lost. It also flags instruction-fetch address errors (AdEL) for the exception logic.

## Interface
- WIDTH, 32, address width
- RESET_VEC, 32'h0000_3000, PC value after reset
- EXC_VEC, 32'h0000_4180, exception/interrupt handler entry
- IMEM_BASE, 32'h0000_3000, lowest legal fetch address
- IMEM_TOP, 32'h0000_6FFF, highest legal fetch byte address
- STEP, 4, sequential increment

Reset is rst, synchronous, active-high; the clock is clk.

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- stall_i  in  1  freeze fetch (hazard stall)
- req_i  in  1  exception/interrupt taken, jump to EXC_VEC
- eret_i  in  1  return from exception
- epc_i  in  WIDTH  return target for ERET
- redir_valid_i  in  1  branch/jump redirect resolved this cycle
- redir_target_i  in  WIDTH  redirect target
- pc_o  out  WIDTH  current fetch PC
- pc_plus_o  out  WIDTH  pc_o + STEP (combinational)
- pend_o  out  1  pending redirect held
- adel_o  out  1  current pc_o is an illegal fetch address

## Operation
- State: pc (WIDTH), pend_v (1), pend_t (WIDTH).
- Next-PC priority, highest first:
  1. rst: pc <= RESET_VEC, pend_v <= 0, pend_t <= 0.
  2. req_i: pc <= EXC_VEC, pend_v <= 0. Overrides stall_i, eret_i, and redirects.
  3. eret_i: pc <= epc_i, pend_v <= 0. Overrides stall_i.
  4. stall_i: pc holds. If redir_valid_i, then pend_v <= 1 and pend_t <= redir_target_i; a later redirect during the same stall overwrites.
  5. redir_valid_i (not stalled): pc <= redir_target_i, pend_v <= 0. A live redirect beats a pending one.
  6. pend_v (not stalled): pc <= pend_t, pend_v <= 0.
  7. Otherwise: pc <= pc + STEP, modulo 2^WIDTH (wraps silently).
- adel_o = (pc[1:0] != 0) | (pc < IMEM_BASE) | (pc > IMEM_TOP - 3). Unsigned compare. adel_o does not alter PC sequencing; the exception unit answers with req_i.
- pend_o = pend_v.

## Timing
- Every output except pc_plus_o and adel_o is registered. pc_plus_o and adel_o are combinational from pc.
- Reset values: pc_o = RESET_VEC, pc_plus_o = RESET_VEC+STEP, pend_o = 0, adel_o = 0 for the default parameters.
- Redirect latency: a redirect sampled at edge N appears on pc_o after edge N. If it is captured during a stall, it appears after the first unstalled edge.
- req_i and eret_i take effect at the next edge regardless of stall_i.
- When req_i and eret_i are asserted together, req_i wins.
- If rst is asserted mid-stall with a pending redirect, the pending entry is discarded.

## Structure
- Package pc_gen_pkg holds the default vector constants (RESET_VEC, EXC_VEC, IMEM_BASE, IMEM_TOP) and the ExcCode value AdEL = 5'd4, shared with the CP0/exception unit.
- Sub-module pc_redir_buf contains the one-entry pending-redirect buffer: pend_v and pend_t, with capture, clear and consume controls. The top level holds the pc register, the priority mux and the AdEL check.

## Test plan
- Reset, then 3 free-run cycles → pc_o = 3000, 3004, 3008, 300C; pend_o = 0.
- At pc = 3010, assert stall_i for 2 cycles with redir_valid_i/redir_target_i = 3400 in the first stall cycle → pc_o holds 3010 and pend_o = 1; after the first unstalled edge pc_o = 3400 and pend_o = 0.
- During a stall, redirect to 3400 and then to 3500; unstall with a live redirect to 3600 → pc_o = 3600, and the pending entry is dropped.
- Assert req_i and eret_i (epc_i = 3020) together while stall_i = 1 → pc_o = 4180. In the next cycle eret_i alone → pc_o = 3020.
- Redirect to 3002 → adel_o = 1. Redirect to 7000 → adel_o = 1. Redirect to 6FFC → adel_o = 0.
- With a pending redirect held, assert rst → pc_o = 3000, pend_o = 0, and the pending target is never fetched.

Source files
------------

// File: rtl/pc_gen_pkg.sv
// Shared constants and types for the fetch-address generator.
// Default vectors, the AdEL exception code, and the next-PC select type.
package pc_gen_pkg;

  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_VEC   = 32'h0000_4180;
  localparam logic [31:0] DEF_IMEM_BASE = 32'h0000_3000;
  localparam logic [31:0] DEF_IMEM_TOP  = 32'h0000_6FFF;
  localparam int          DEF_STEP      = 4;

  // ExcCode reported by CP0 for an instruction-fetch address error.
  localparam logic [4:0]  EXC_ADEL      = 5'd4;

  typedef enum logic [2:0] {
    SEL_SEQ,
    SEL_EXC,
    SEL_ERET,
    SEL_HOLD,
    SEL_REDIR,
    SEL_PEND
  } pc_sel_e;

endpackage

// File: rtl/pc_gen_if.sv
// Fetch-control bundle between the pipeline control side and pc_gen.
// master: stall/req/eret/epc/redirect in, pc/pc_plus/pend/adel back.
interface pc_gen_if #(
  parameter int WIDTH = 32
);

  logic             stall_i;
  logic             req_i;
  logic             eret_i;
  logic [WIDTH-1:0] epc_i;
  logic             redir_valid_i;
  logic [WIDTH-1:0] redir_target_i;
  logic [WIDTH-1:0] pc_o;
  logic [WIDTH-1:0] pc_plus_o;
  logic             pend_o;
  logic             adel_o;

  modport master (
    output stall_i,
    output req_i,
    output eret_i,
    output epc_i,
    output redir_valid_i,
    output redir_target_i,
    input  pc_o,
    input  pc_plus_o,
    input  pend_o,
    input  adel_o
  );

  modport slave (
    input  stall_i,
    input  req_i,
    input  eret_i,
    input  epc_i,
    input  redir_valid_i,
    input  redir_target_i,
    output pc_o,
    output pc_plus_o,
    output pend_o,
    output adel_o
  );

endinterface

// File: rtl/pc_redir_buf.sv
// One-entry buffer holding a redirect resolved while fetch is stalled.
// Ports: clk/rst, capture/clear/consume controls, target in, pend_v/pend_t out.
module pc_redir_buf #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             capture,
  input  logic             clear,
  input  logic             consume,
  input  logic [WIDTH-1:0] target,
  output logic             pend_v,
  output logic [WIDTH-1:0] pend_t
);

  // clear (exception/eret) beats capture; a newer capture overwrites.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_v <= 1'b0;
      pend_t <= '0;
    end else if (clear) begin
      pend_v <= 1'b0;
    end else if (capture) begin
      pend_v <= 1'b1;
      pend_t <= target;
    end else if (consume) begin
      pend_v <= 1'b0;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC register with exception/ERET vectors, stall-safe redirects, AdEL.
// Ports: clk, rst (sync, active-high), bus (pc_gen_if slave).
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int             WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(DEF_RESET_VEC),
  parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(DEF_EXC_VEC),
  parameter logic [WIDTH-1:0] IMEM_BASE = WIDTH'(DEF_IMEM_BASE),
  parameter logic [WIDTH-1:0] IMEM_TOP  = WIDTH'(DEF_IMEM_TOP),
  parameter int             STEP      = DEF_STEP
) (
  input  logic   clk,
  input  logic   rst,
  pc_gen_if.slave bus
);

  // Last word start that still fits entirely below IMEM_TOP.
  localparam logic [WIDTH-1:0] LAST_WORD = IMEM_TOP - WIDTH'(3);

  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_next;
  logic [WIDTH-1:0] pc_plus;
  logic             pend_v;
  logic [WIDTH-1:0] pend_t;
  logic             capture;
  logic             clear;
  logic             consume;
  logic             adel;
  pc_sel_e          sel;

  assign pc_plus = pc + WIDTH'(STEP);

  always_comb begin
    sel = SEL_SEQ;
    if (bus.req_i)
      sel = SEL_EXC;
    else if (bus.eret_i)
      sel = SEL_ERET;
    else if (bus.stall_i)
      sel = SEL_HOLD;
    else if (bus.redir_valid_i)
      sel = SEL_REDIR;
    else if (pend_v)
      sel = SEL_PEND;
  end

  always_comb begin
    pc_next = pc_plus;
    unique case (sel)
      SEL_EXC:   pc_next = EXC_VEC;
      SEL_ERET:  pc_next = bus.epc_i;
      SEL_HOLD:  pc_next = pc;
      SEL_REDIR: pc_next = bus.redir_target_i;
      SEL_PEND:  pc_next = pend_t;
      SEL_SEQ:   pc_next = pc_plus;
      default:   pc_next = pc_plus;
    endcase
  end

  // Any unstalled edge retires the pending entry, used or overridden.
  assign clear   = (sel == SEL_EXC) | (sel == SEL_ERET);
  assign capture = (sel == SEL_HOLD) & bus.redir_valid_i;
  assign consume = ~bus.stall_i;

  pc_redir_buf #(
    .WIDTH (WIDTH)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .capture (capture),
    .clear   (clear),
    .consume (consume),
    .target  (bus.redir_target_i),
    .pend_v  (pend_v),
    .pend_t  (pend_t)
  );

  always_ff @(posedge clk) begin
    if (rst)
      pc <= RESET_VEC;
    else
      pc <= pc_next;
  end

  assign adel = (pc[1:0] != 2'b00)
              | (pc < IMEM_BASE)
              | (pc > LAST_WORD);

  assign bus.pc_o      = pc;
  assign bus.pc_plus_o = pc_plus;
  assign bus.pend_o    = pend_v;
  assign bus.adel_o    = adel;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed vector table, reset corner,
// and randomized traffic against a behavioural model.
module tb_pc_gen;

  logic clk;
  logic rst;

  pc_gen_if #(.WIDTH(32)) bus ();

  pc_gen dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        req;
    logic        eret;
    logic [31:0] epc;
    logic        rv;
    logic [31:0] rt;
    logic [31:0] pc;
    logic        pend;
    logic        adel;
  } vec_t;

  int passed;
  int total;

  // Model state
  longint unsigned m_pc;
  bit              m_pv;
  longint unsigned m_pt;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    if (got === want)
      passed++;
    else
      $display("FAIL %s got %h want %h", nm, got, want);
  endtask

  function automatic vec_t mk(input logic s, input logic q, input logic e,
                              input logic [31:0] ep, input logic v,
                              input logic [31:0] t, input logic [31:0] p,
                              input logic pd, input logic ad);
    vec_t r;
    r.stall = s; r.req = q; r.eret = e; r.epc = ep;
    r.rv = v; r.rt = t; r.pc = p; r.pend = pd; r.adel = ad;
    return r;
  endfunction

  function automatic bit legal(input longint unsigned a);
    return (a % 4 == 0) && (a >= 64'h3000) && (a + 3 <= 64'h6FFF);
  endfunction

  task automatic drive(input logic s, input logic q, input logic e,
                       input logic [31:0] ep, input logic v,
                       input logic [31:0] t);
    bus.stall_i        = s;
    bus.req_i          = q;
    bus.eret_i         = e;
    bus.epc_i          = ep;
    bus.redir_valid_i  = v;
    bus.redir_target_i = t;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string nm, input logic [31:0] p,
                           input logic pd, input logic ad);
    chk({nm, ".pc"}, bus.pc_o, p);
    chk({nm, ".pc_plus"}, bus.pc_plus_o, p + 32'd4);
    chk({nm, ".pend"}, {31'd0, bus.pend_o}, {31'd0, pd});
    chk({nm, ".adel"}, {31'd0, bus.adel_o}, {31'd0, ad});
  endtask

  vec_t vecs[$];

  initial begin
    passed = 0;
    total  = 0;

    vecs.push_back(mk(0,0,0,0,0,0,              32'h3004,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,              32'h3008,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,              32'h300C,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,              32'h3010,0,0));
    vecs.push_back(mk(1,0,0,0,1,32'h3400,       32'h3010,1,0));
    vecs.push_back(mk(1,0,0,0,0,0,              32'h3010,1,0));
    vecs.push_back(mk(0,0,0,0,0,0,              32'h3400,0,0));
    vecs.push_back(mk(1,0,0,0,1,32'h3400,       32'h3400,1,0));
    vecs.push_back(mk(1,0,0,0,1,32'h3500,       32'h3400,1,0));
    vecs.push_back(mk(0,0,0,0,1,32'h3600,       32'h3600,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,              32'h3604,0,0));
    vecs.push_back(mk(1,1,1,32'h3020,0,0,       32'h4180,0,0));
    vecs.push_back(mk(0,0,1,32'h3020,0,0,       32'h3020,0,0));
    vecs.push_back(mk(0,0,0,0,1,32'h3002,       32'h3002,0,1));
    vecs.push_back(mk(0,0,0,0,1,32'h7000,       32'h7000,0,1));
    vecs.push_back(mk(0,0,0,0,1,32'h6FFC,       32'h6FFC,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,              32'h7000,0,1));
    vecs.push_back(mk(0,0,0,0,1,32'h2FFC,       32'h2FFC,0,1));
    vecs.push_back(mk(1,0,0,0,1,32'h5000,       32'h2FFC,1,1));
    vecs.push_back(mk(1,1,0,0,1,32'h5100,       32'h4180,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,              32'h4184,0,0));
    vecs.push_back(mk(1,0,0,0,1,32'h5000,       32'h4184,1,0));
    vecs.push_back(mk(1,0,1,32'h3100,0,0,       32'h3100,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,              32'h3104,0,0));
    vecs.push_back(mk(0,0,0,0,1,32'hFFFF_FFFC,  32'hFFFF_FFFC,0,1));
    vecs.push_back(mk(0,0,0,0,0,0,              32'h0000_0000,0,1));

    rst = 1'b1;
    drive(0,0,0,0,0,0);
    tick();
    tick();
    check_all("reset", 32'h3000, 1'b0, 1'b0);

    rst = 1'b0;
    foreach (vecs[i]) begin
      drive(vecs[i].stall, vecs[i].req, vecs[i].eret, vecs[i].epc,
            vecs[i].rv, vecs[i].rt);
      tick();
      check_all($sformatf("vec%0d", i), vecs[i].pc, vecs[i].pend,
                vecs[i].adel);
    end

    // Reset during a stall with a pending redirect drops the entry.
    drive(1,0,0,0,1,32'h5000);
    tick();
    check_all("rstpend.hold", 32'h0000_0000, 1'b1, 1'b1);
    rst = 1'b1;
    drive(1,0,0,0,0,0);
    tick();
    check_all("rstpend.rst", 32'h3000, 1'b0, 1'b0);
    rst = 1'b0;
    drive(0,0,0,0,0,0);
    tick();
    check_all("rstpend.run1", 32'h3004, 1'b0, 1'b0);
    tick();
    check_all("rstpend.run2", 32'h3008, 1'b0, 1'b0);

    // Randomized traffic vs. model
    m_pc = 64'h3008;
    m_pv = 1'b0;
    m_pt = 0;
    for (int n = 0; n < 400; n++) begin
      logic        s, q, e, v, r;
      logic [31:0] ep, t;
      s = ($urandom_range(0, 99) < 35);
      q = ($urandom_range(0, 99) < 5);
      e = ($urandom_range(0, 99) < 6);
      v = ($urandom_range(0, 99) < 35);
      r = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 9) < 7)
        t = 32'h3000 + 32'($urandom_range(0, 32'hFFF)) * 4;
      else
        t = $urandom;
      if ($urandom_range(0, 9) < 8)
        ep = 32'h3000 + 32'($urandom_range(0, 32'hFFF)) * 4;
      else
        ep = $urandom;
      rst = r;
      drive(s, q, e, ep, v, t);
      tick();
      if (r) begin
        m_pc = 64'h3000;
        m_pv = 1'b0;
        m_pt = 0;
      end else if (q) begin
        m_pc = 64'h4180;
        m_pv = 1'b0;
      end else if (e) begin
        m_pc = ep;
        m_pv = 1'b0;
      end else if (s) begin
        if (v) begin
          m_pv = 1'b1;
          m_pt = t;
        end
      end else if (v) begin
        m_pc = t;
        m_pv = 1'b0;
      end else if (m_pv) begin
        m_pc = m_pt;
        m_pv = 1'b0;
      end else begin
        m_pc = (m_pc + 4) % 64'h1_0000_0000;
      end
      check_all($sformatf("rnd%0d", n), 32'(m_pc), m_pv, !legal(m_pc));
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
